// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-wide synchronous memory.
// Byte and halfword stores are done as read-modify-write.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, RD, WT, WR, FIN
  } state_t;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b011;
  localparam logic [2:0] OP_SH = 3'b100;
  localparam logic [2:0] OP_SB = 3'b101;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;

  logic        bad_in;
  logic        is_load;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] ld_word;
  logic [31:0] mask;
  logic [31:0] ins;

  always_comb begin
    bad_in = 1'b0;
    unique case (1'b1)
      (op == OP_LW), (op == OP_SW):
        bad_in = (addr_in[1:0] != 2'b00);
      (op == OP_LH), (op == OP_SH):
        bad_in = addr_in[0];
      (op == OP_LB), (op == OP_SB):
        bad_in = 1'b0;
      default:
        bad_in = 1'b1;
    endcase
  end

  assign is_load = (op_q == OP_LW) || (op_q == OP_LH) ||
                   (op_q == OP_LB);
  assign bsh = {addr_q[1:0], 3'b000};
  assign hsh = {addr_q[1], 4'b0000};

  always_comb begin
    ld_word = mem_rdata;
    mask    = 32'h0000_00ff << bsh;
    ins     = {24'h0, wdata_q[7:0]} << bsh;
    if (op_q == OP_LH) begin
      ld_word = {16'h0, mem_rdata[hsh +: 16]};
    end else if (op_q == OP_LB) begin
      ld_word = {24'h0, mem_rdata[bsh +: 8]};
    end
    if (op_q == OP_SH) begin
      mask = 32'h0000_ffff << hsh;
      ins  = {16'h0, wdata_q[15:0]} << hsh;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_in;
          op_d    = op;
          wdata_d = wdata;
          err_d   = bad_in;
          if (bad_in)
            state_d = FIN;
          else if (op == OP_SW)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: state_d = WT;
      WT: begin
        if (is_load) begin
          rdata_d = ld_word;
          state_d = FIN;
        end else begin
          wdata_d = (mem_rdata & ~mask) | ins;
          state_d = WR;
        end
      end
      WR:  state_d = FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registered state, so reset clears them at once.
  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (state_q == RD || state_q == WT || state_q == WR)
      mem_addr = {addr_q[31:2], 2'b00};
    if (state_q == WR) begin
      mem_wr    = 1'b1;
      mem_wdata = wdata_q;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign err   = (state_q == FIN) && err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a synchronous memory
// model and queues of expected writes and completions.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr_in = '0;
  logic        req = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  logic [63:0] wq[$];
  logic [32:0] rq[$];

  mem_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .req       (req),
    .op        (op),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_wr === 1'b1)
      mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_wr !== 1'b0) begin
      logic [63:0] e;
      if (wq.size() == 0) begin
        check("unexpected_write", {31'h0, mem_wr}, 32'h0);
      end else begin
        e = wq.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic access(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int lat,
                        input logic e_err, input logic [31:0] e_rd,
                        input logic has_wr, input logic [31:0] w_a,
                        input logic [31:0] w_d);
    int n;
    logic [32:0] r;
    logic bsy_bad;
    if (has_wr) wq.push_back({w_a, w_d});
    rq.push_back({e_err, e_rd});
    @(negedge clk);
    req = 1'b1; op = o; addr_in = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    op = 3'($urandom);
    addr_in = $urandom;
    wdata = $urandom;
    n = 1;
    bsy_bad = 1'b0;
    while (done !== 1'b1 && n < 10) begin
      if (busy !== 1'b1) bsy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    r = rq.pop_front();
    check("latency", n, lat);
    check("busy_during", {31'h0, bsy_bad}, 32'h0);
    check("busy_fin", {31'h0, busy}, 32'h1);
    check("err", {31'h0, err}, {31'h0, r[32]});
    check("rdata", rdata, r[31:0]);
    @(posedge clk); #1;
    check("done_after", {31'h0, done}, 32'h0);
    check("busy_after", {31'h0, busy}, 32'h0);
    check("err_after", {31'h0, err}, 32'h0);
    check("wq_empty", wq.size(), 32'h0);
  endtask

  initial begin
    int dn;
    int idl;
    int bad;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEAD_BEEF;
    mem[63] = 32'h1122_3344;
    mem[8]  = 32'h1122_3344;
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    access(3'b000, 32'h10, 0, 3, 0, 32'hDEAD_BEEF, 0, 0, 0);
    access(3'b010, 32'd253, 0, 3, 0, 32'h33, 0, 0, 0);
    access(3'b010, 32'd255, 0, 3, 0, 32'h11, 0, 0, 0);
    access(3'b001, 32'h22, 0, 3, 0, 32'h1122, 0, 0, 0);
    access(3'b100, 32'h22, 32'hFFFF_ABCD, 4, 0, 32'h1122,
           1, 32'h20, 32'hABCD_3344);
    access(3'b000, 32'h20, 0, 3, 0, 32'hABCD_3344, 0, 0, 0);
    access(3'b101, 32'h21, 32'h1234_5677, 4, 0, 32'hABCD_3344,
           1, 32'h20, 32'hABCD_7744);
    access(3'b001, 32'h20, 0, 3, 0, 32'h7744, 0, 0, 0);
    access(3'b000, 32'h13, 0, 1, 1, 32'h7744, 0, 0, 0);
    access(3'b111, 32'h10, 0, 1, 1, 32'h7744, 0, 0, 0);
    access(3'b100, 32'h21, 0, 1, 1, 32'h7744, 0, 0, 0);
    access(3'b011, 32'h0C, 32'hCAFE_F00D, 2, 0, 32'h7744,
           1, 32'h0C, 32'hCAFE_F00D);
    access(3'b000, 32'h0C, 0, 3, 0, 32'hCAFE_F00D, 0, 0, 0);

    // req held high: RD, WT, FIN, IDLE repeating
    @(negedge clk);
    req = 1'b1; op = 3'b000; addr_in = 32'h10;
    dn = 0; idl = 0; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
      if (busy === 1'b0) idl++;
      if ((k % 4 == 3) != (done === 1'b1)) bad++;
      if ((k % 4 == 0) != (busy === 1'b0)) bad++;
    end
    req = 1'b0;
    check("b2b_dones", dn, 4);
    check("b2b_idles", idl, 4);
    check("b2b_pattern", bad, 0);
    check("b2b_rdata", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("b2b_idle_end", {31'h0, busy}, 32'h0);

    // reset during WT of an SB
    @(negedge clk);
    req = 1'b1; op = 3'b101; addr_in = 32'h9; wdata = 32'hEE;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("sb_in_wt_addr", mem_addr, 32'h8);
    reset = 1'b0;
    #1;
    check("rst2_busy", {31'h0, busy}, 32'h0);
    check("rst2_done", {31'h0, done}, 32'h0);
    check("rst2_err", {31'h0, err}, 32'h0);
    check("rst2_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst2_addr", mem_addr, 32'h0);
    check("rst2_wdata", mem_wdata, 32'h0);
    check("rst2_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    access(3'b011, 32'h8, 32'h5, 2, 0, 32'h0, 1, 32'h8, 32'h5);
    access(3'b000, 32'h8, 0, 3, 0, 32'h5, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
